bin_bcd_dabble: RTL

BIN_BCD_DABBLE -- requirements
Module: bin_bcd_dabble

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_bcd_dabble.sv | 111 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared digit codes, FSM states and digit type for the sign-magnitude to BCD converter.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam digit_t DIG_MINUS = 4'hA;
  localparam digit_t DIG_BLANK = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  digit_t dig_i,
  output digit_t dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/bin_bcd_dabble.sv
// Sign-magnitude to sign+3-digit BCD; result valid MAG_W+1 edges after accept, held until out_ready.
// Build option BCD_LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module bin_bcd_dabble
  import bcd_pkg::*;
#(
  parameter int MAG_W  = 8,
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MAG_W:0]         bin_v,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DIGITS-1:0][3:0] data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAG_W + 1);
  localparam int BCD_W = (DIGITS - 1) * 4;

  if (MAG_W > 9 || DIGITS != 4) begin : g_bad_cfg
    $error("bin_bcd_dabble: MAG_W must be <= 9 and DIGITS must be 4");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAG_W-1:0]       mag_q, mag_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d, bcd_adj;
  logic                   neg_q, neg_d;
  logic [DIGITS-1:0][3:0] data_q, data_d, result;

  for (genvar g = 0; g < DIGITS - 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .dig_i(bcd_q[g*4 +: 4]),
      .dig_o(bcd_adj[g*4 +: 4])
    );
  end

  always_comb begin
    result    = '0;
    result[3] = neg_q ? DIG_MINUS : DIG_BLANK;
    result[2] = bcd_q[11:8];
    result[1] = bcd_q[7:4];
    result[0] = bcd_q[3:0];
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (bcd_q[11:8] == 4'd0) result[2] = DIG_BLANK;
    if (bcd_q[11:4] == 8'd0) result[1] = DIG_BLANK;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = bin_v[MAG_W-1:0];
          // negative zero is shown as plain zero
          neg_d   = bin_v[MAG_W] && (bin_v[MAG_W-1:0] != '0);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(MAG_W)) begin
          data_d  = result;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          {bcd_d, mag_d} = {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
          cnt_d          = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      data_q  <= {DIG_BLANK, {BCD_W{1'b0}}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign data      = data_q;

endmodule
